noc_local_ni: RTL and testbench

Local network interface for one mesh node. It sits between the processing element (PE) and the router's local (L) port. On the inject side it packs PE transmit requests into flits and writes them into the router's L input FIFO under full/almost-full backpressure. On the eject side it buffers flits delivered on the router's L output in a small first-word-fall-through (FWFT) receive FIFO and returns full/almost-full status to the router.

---
 rtl/noc_pkg.sv | 28 ++
 rtl/noc_local_ni_if.sv | 55 +++++
 rtl/ni_rx_fifo.sv | 77 +++++++
 rtl/noc_local_ni.sv | 122 ++++++++++++
 tb/tb_noc_local_ni.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared constants and helpers for the local network interface.
//               Flits carry the destination ID in their top DEST_W bits and
//               the payload in the remaining low bits.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int DEST_W   = 2;
    localparam int FLIT_W   = 16;
    localparam int DEST_MSB = FLIT_W - 1;
    localparam int DEST_LSB = FLIT_W - 2;

    // Widest flit the dest helper accepts; callers zero-extend into this.
    localparam int MAX_W    = 64;

    // Returns the destination field of a flit that is `width` bits wide.
    // The flit is passed right-aligned in a MAX_W container so one helper
    // serves every WIDTH parameterisation.
    function automatic logic [DEST_W-1:0] flitDest(input logic [MAX_W-1:0] flit,
                                                   input int width);
        return DEST_W'(flit >> (width - DEST_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_local_ni_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_local_ni_if
// Description : Bundle of PE-side and router-side signals of the local NI.
//               slave  : view of the NI itself.
//               master : view of the environment (PE + router L port).
//   PE inject   : tx_valid, tx_ready, tx_dest, tx_payload
//   Router in   : dataInL, writeL, fullL, almost_fullL
//   Router out  : dataOutL, writeOutL, readFullL, read_almostfullL
//   PE eject    : rx_valid, rx_ready, rx_data
//   Status      : misroute
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_local_ni_if #(
    parameter int WIDTH = 16
);
    import noc_pkg::*;

    logic                   tx_valid;
    logic                   tx_ready;
    logic [DEST_W-1:0]      tx_dest;
    logic [WIDTH-3:0]       tx_payload;

    logic [WIDTH-1:0]       dataInL;
    logic                   writeL;
    logic                   fullL;
    logic                   almost_fullL;

    logic [WIDTH-1:0]       dataOutL;
    logic                   writeOutL;
    logic                   readFullL;
    logic                   read_almostfullL;

    logic                   rx_valid;
    logic                   rx_ready;
    logic [WIDTH-1:0]       rx_data;

    logic                   misroute;

    modport slave (
        input  tx_valid, tx_dest, tx_payload, fullL, almost_fullL,
               dataOutL, writeOutL, rx_ready,
        output tx_ready, dataInL, writeL, readFullL, read_almostfullL,
               rx_valid, rx_data, misroute
    );

    modport master (
        output tx_valid, tx_dest, tx_payload, fullL, almost_fullL,
               dataOutL, writeOutL, rx_ready,
        input  tx_ready, dataInL, writeL, readFullL, read_almostfullL,
               rx_valid, rx_data, misroute
    );

endinterface
`default_nettype wire

// File: rtl/ni_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ni_rx_fifo
// Description : First-word-fall-through receive FIFO for the eject path.
//               A push while full is refused even when a pop happens in the
//               same cycle. Full / almost-full are registered from the
//               next-state count so they reflect the count after each edge.
//   clk, reset (async, active low)
//   i_push, i_pushData          : write side
//   i_pop                       : read side (ignored while empty)
//   o_headData                  : head entry, zero while empty
//   o_full, o_almostFull, o_empty, o_count : status
// Revision    : 1.0 - initial release
// ============================================================================
module ni_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_pushData,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_headData,
    output logic                      o_full,
    output logic                      o_almostFull,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int             c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL  = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]  c_AFULL = (c_AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wrPtr;
    logic [c_AW-1:0]  r_rdPtr;
    logic [c_AW:0]    r_count;
    logic             r_full;
    logic             r_almostFull;

    logic             w_push;
    logic             w_pop;
    logic [c_AW:0]    w_countNext;

    assign w_push      = i_push & ~r_full;
    assign w_pop       = i_pop & (r_count != '0);
    assign w_countNext = r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_almostFull <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_AW'(1);
            r_count      <= w_countNext;
            r_full       <= (w_countNext == c_FULL);
            r_almostFull <= (w_countNext >= c_AFULL);
        end
    end

    // Storage needs no reset: the head output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_empty      = (r_count == '0);
    assign o_headData   = o_empty ? '0 : r_mem[r_rdPtr];
    assign o_full       = r_full;
    assign o_almostFull = r_almostFull;
    assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module      : noc_local_ni
// Description : Local network interface between a PE and the router L port.
//               Inject: registers accepted PE flits into the router L FIFO.
//               Eject : buffers router flits in an FWFT FIFO for the PE and
//               flags any flit whose destination is not this node.
//   clk, reset (async, active low)
//   bus   : noc_local_ni_if.slave (PE and router handshakes, misroute)
//   Optional macro NOC_NI_STATS_EN adds saturating 16-bit counters
//   tx_count, rx_count, drop_count as extra output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_local_ni
    import noc_pkg::*;
#(
    parameter int                WIDTH    = 16,
    parameter logic [DEST_W-1:0] LOCAL_IP = 2'b00,
    parameter int                RX_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    noc_local_ni_if.slave        bus
`ifdef NOC_NI_STATS_EN
    ,
    output logic [15:0]          tx_count,
    output logic [15:0]          rx_count,
    output logic [15:0]          drop_count
`endif
);
    // ---------------------------------------------------------------- inject
    logic             w_txReady;
    logic             w_txFire;
    logic             r_writeL;
    logic [WIDTH-1:0] r_dataInL;

    // almost_full gating leaves one slot for the flit already in the register.
    assign w_txReady = ~bus.fullL & ~bus.almost_fullL;
    assign w_txFire  = bus.tx_valid & w_txReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_writeL  <= 1'b0;
            r_dataInL <= '0;
        end else begin
            r_writeL <= w_txFire;
            if (w_txFire) r_dataInL <= {bus.tx_dest, bus.tx_payload};
        end
    end

    assign bus.tx_ready = w_txReady;
    assign bus.writeL   = r_writeL;
    assign bus.dataInL  = r_dataInL;

    // ----------------------------------------------------------------- eject
    logic                      w_rxFull;
    logic                      w_rxEmpty;
    logic                      w_rxAccept;
    logic                      w_rxDrop;
    logic [$clog2(RX_DEPTH):0] w_rxCount;
    logic                      w_unusedCount;
    logic                      r_misroute;

    assign w_rxAccept    = bus.writeOutL & ~w_rxFull;
    assign w_rxDrop      = bus.writeOutL &  w_rxFull;
    assign w_unusedCount = ^w_rxCount;

    ni_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rxFifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (bus.writeOutL),
        .i_pushData   (bus.dataOutL),
        .i_pop        (bus.rx_ready),
        .o_headData   (bus.rx_data),
        .o_full       (w_rxFull),
        .o_almostFull (bus.read_almostfullL),
        .o_empty      (w_rxEmpty),
        .o_count      (w_rxCount)
    );

    assign bus.readFullL = w_rxFull;
    assign bus.rx_valid  = ~w_rxEmpty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misroute <= 1'b0;
        end else if (w_rxAccept &&
                     (flitDest(MAX_W'(bus.dataOutL), WIDTH) != LOCAL_IP)) begin
            r_misroute <= 1'b1;
        end
    end

    assign bus.misroute = r_misroute;

`ifdef NOC_NI_STATS_EN
    // ----------------------------------------------------------------- stats
    logic [15:0] r_txCount;
    logic [15:0] r_rxCount;
    logic [15:0] r_dropCount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txCount   <= '0;
            r_rxCount   <= '0;
            r_dropCount <= '0;
        end else begin
            if (r_writeL   && (r_txCount   != 16'hFFFF)) r_txCount   <= r_txCount   + 16'd1;
            if (w_rxAccept && (r_rxCount   != 16'hFFFF)) r_rxCount   <= r_rxCount   + 16'd1;
            if (w_rxDrop   && (r_dropCount != 16'hFFFF)) r_dropCount <= r_dropCount + 16'd1;
        end
    end

    assign tx_count   = r_txCount;
    assign rx_count   = r_rxCount;
    assign drop_count = r_dropCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_local_ni
// Description : Scoreboard bench for noc_local_ni. The stimulus process
//               predicts every injected flit and every accepted eject flit
//               into queues; a negedge monitor pops and compares whenever the
//               DUT presents writeL or rx_valid. Status outputs are checked
//               one step after each edge against a count-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_local_ni;

    localparam int DEPTH = 8;

    typedef struct {
        int          due;
        logic [15:0] flit;
    } tx_exp_t;

    logic clk;
    logic reset;

    noc_local_ni_if #(.WIDTH(16)) bus ();

`ifdef NOC_NI_STATS_EN
    logic [15:0] txCount, rxCount, dropCount;
`endif

    noc_local_ni #(
        .WIDTH    (16),
        .LOCAL_IP (2'b00),
        .RX_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef NOC_NI_STATS_EN
        ,
        .tx_count   (txCount),
        .rx_count   (rxCount),
        .drop_count (dropCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nVec = 0;
    int nErr = 0;

    tx_exp_t     txQ[$];
    logic [15:0] rxQ[$];
    int          mCnt      = 0;
    logic        mMis      = 1'b0;
    logic        expTxReady = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), update the
    // reference model with what the next edge should do, then check status.
    task automatic drive(input logic tv, input logic [1:0] td, input logic [13:0] tp,
                         input logic fl, input logic afl,
                         input logic wo, input logic [15:0] dOut, input logic rr);
        logic pushOk, popOk;
        bus.tx_valid     = tv;
        bus.tx_dest      = td;
        bus.tx_payload   = tp;
        bus.fullL        = fl;
        bus.almost_fullL = afl;
        bus.writeOutL    = wo;
        bus.dataOutL     = dOut;
        bus.rx_ready     = rr;

        expTxReady = !(fl || afl);
        if (tv && expTxReady) txQ.push_back('{due: cyc + 1, flit: {td, tp}});

        pushOk = wo && (mCnt < DEPTH);
        popOk  = rr && (mCnt > 0);
        if (pushOk) begin
            rxQ.push_back(dOut);
            if (dOut[15:14] != 2'b00) mMis = 1'b1;
        end
        mCnt = mCnt + (pushOk ? 1 : 0) - (popOk ? 1 : 0);

        @(posedge clk);
        #1;
        chk("rx_valid",         bus.rx_valid,         mCnt > 0);
        chk("readFullL",        bus.readFullL,        mCnt == DEPTH);
        chk("read_almostfullL", bus.read_almostfullL, mCnt >= DEPTH - 1);
        chk("misroute",         bus.misroute,         mMis);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 14'h0, 1'b0, 1'b0, 1'b0, 16'h0, rr);
    endtask

    // Monitor: mid-cycle, compare whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (reset) begin
            logic expW;
            chk("tx_ready", bus.tx_ready, expTxReady);
            expW = (txQ.size() > 0) && (txQ[0].due == cyc);
            chk("writeL", bus.writeL, expW);
            if (bus.writeL && expW) begin
                chk("dataInL", bus.dataInL, txQ[0].flit);
                void'(txQ.pop_front());
            end
            if (bus.rx_valid) begin
                if (rxQ.size() == 0) begin
                    chk("rx_spurious", 1, 0);
                end else begin
                    chk("rx_data", bus.rx_data, rxQ[0]);
                    if (bus.rx_ready) void'(rxQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [1:0]  d;
        logic [15:0] f;
        reset = 1'b0;
        bus.tx_valid = 0; bus.tx_dest = 0; bus.tx_payload = 0;
        bus.fullL = 0; bus.almost_fullL = 0;
        bus.writeOutL = 0; bus.dataOutL = 0; bus.rx_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_writeL",   bus.writeL,           0);
        chk("rst_dataInL",  bus.dataInL,          0);
        chk("rst_rx_valid", bus.rx_valid,         0);
        chk("rst_rx_data",  bus.rx_data,          0);
        chk("rst_full",     bus.readFullL,        0);
        chk("rst_afull",    bus.read_almostfullL, 0);
        chk("rst_misroute", bus.misroute,         0);
        chk("rst_tx_ready", bus.tx_ready,         1);
        reset = 1'b1;

        // Single inject: {01, 0ABC} must appear as 4ABC one edge later
        drive(1'b1, 2'b01, 14'h0ABC, 0, 0, 0, 16'h0, 0);
        chk("inject_4ABC", bus.dataInL, 16'h4ABC);
        idle(2, 0);

        // Backpressure via almost_full, then full, then release
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b10, 14'h1234, 0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 2; i++) drive(1'b1, 2'b10, 14'h1234, 1, 0, 0, 16'h0, 0);
        drive(1'b1, 2'b10, 14'h1234, 0, 0, 0, 16'h0, 0);
        idle(2, 0);

        // Loopback destination passes through unchanged
        drive(1'b1, 2'b00, 14'h3FFF, 0, 0, 0, 16'h0, 0);
        idle(1, 0);

        // Eject fill: 8 accepted, 9th dropped, then drain in order
        for (int i = 0; i < DEPTH + 1; i++)
            drive(1'b0, 2'b00, 14'h0, 0, 0, 1'b1, 16'h0100 + 16'(i), 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Simultaneous push/pop with pointer wrap, count held at 3
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 14'h0, 0, 0, 1'b1, 16'h0200 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 2'b00, 14'h0, 0, 0, 1'b1, 16'h0300 + 16'(i), 1'b1);
        idle(5, 1'b1);

        // Misroute: 8001 is stored and the flag sticks
        drive(1'b0, 2'b00, 14'h0, 0, 0, 1'b1, 16'h8001, 1'b0);
        idle(4, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            f = {d, 14'($urandom)};
            drive($urandom_range(0, 9) < 7, 2'($urandom), 14'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3,
                  $urandom_range(0, 9) < 6, f, $urandom_range(0, 1) == 1);
        end
        idle(DEPTH + 2, 1'b1);

        // Mid-stream reset: writeL drops within the same cycle
        drive(1'b0, 2'b00, 14'h0, 0, 0, 1'b1, 16'h0055, 1'b0);
        drive(1'b1, 2'b11, 14'h2AAA, 0, 0, 1'b1, 16'h0066, 1'b0);
        bus.tx_valid = 1'b0; bus.writeOutL = 1'b0;
        txQ.delete(); rxQ.delete(); mCnt = 0; mMis = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_writeL",   bus.writeL,   0);
        chk("midrst_dataInL",  bus.dataInL,  0);
        chk("midrst_rx_valid", bus.rx_valid, 0);
        chk("midrst_misroute", bus.misroute, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3, 1'b0);

        // Short random run after reset, then drain
        for (int i = 0; i < 60; i++) begin
            f = {2'b00, 14'($urandom)};
            drive($urandom_range(0, 1) == 1, 2'($urandom), 14'($urandom), 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, f,
                  $urandom_range(0, 1) == 1);
        end
        idle(DEPTH + 2, 1'b1);

        chk("tx_queue_drained", txQ.size(), 0);
        chk("rx_queue_drained", rxQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
